tt_dpll_lock_ctrl: RTL and testbench
====================================

// Module: tt_dpll_lock_ctrl
// PURPOSE
//  Acquisition/lock sequencer for the DPLL loop. Measures phase-error activity (PFD up/down) once per
//  reference window (one o_clk_div period) and steps loop-filter gain COARSE -> FINE -> LOCKED.
//  Declares/de-asserts lock with hysteresis; restarts acquisition on loss of lock or timeout.
//  Sits beside the PFD/LPF; drives LPF gain select and clear; joins the DPLL scan chain.
// PARAMETERS
//  ERR_W          8     width of per-window error counter (saturating)
//  COARSE_THRESH  8     max error cycles/window counted as "good" in COARSE
//  FINE_THRESH    1     max error cycles/window counted as "good" in FINE/LOCKED
//  COARSE_WINDOWS 4     consecutive good windows to leave COARSE (>=1)
//  LOCK_WINDOWS   16    consecutive good windows in FINE to declare lock (>=1)
//  UNLOCK_WINDOWS 3     consecutive bad windows in LOCKED to declare loss (>=1)
//  ACQ_TIMEOUT    1024  max windows spent in COARSE+FINE before forced restart
// PORTS
//  o_clk_gen    in   1      clock (DPLL generated clock)
//  i_rst_n      in   1      async active-low reset
//  i_enable     in   1      run acquisition; low forces IDLE
//  i_up         in   1      PFD up
//  i_down       in   1      PFD down
//  i_clk_div    in   1      divided feedback clock (o_clk_gen domain); rising edge = window end
//  i_clr_lost   in   1      clears o_lock_lost sticky
//  o_gain_sel   out  2      LPF gain: 2'b10 coarse, 2'b01 fine, 2'b00 locked/track
//  o_lpf_clear  out  1      clear LPF integrator
//  o_locked     out  1      lock indicator (registered)
//  o_lock_lost  out  1      sticky loss-of-lock / timeout flag
//  o_state      out  3      FSM state, debug
//  i_scan_en    in   1      scan shift enable
//  i_scan_in    in   1      scan data in
//  o_scan_out   out  1      scan data out
// BEHAVIOUR
//  Reset: state=IDLE(0), all counters 0, o_gain_sel=2'b10, o_lpf_clear=1, o_locked=0, o_lock_lost=0.
//  Window: win_end = i_clk_div & ~div_q (div_q = i_clk_div delayed 1 cycle, reset 0).
//   err_cnt += (i_up|i_down) each non-win_end cycle, saturates at 2^ERR_W-1.
//   On win_end: evaluate e = err_cnt (edge cycle excluded); err_cnt <= (i_up|i_down).
//  States: IDLE=0 COARSE=1 FINE=2 LOCKED=3 LOST=4; all outputs registered, decoded from next state.
//   IDLE:   gain 10, lpf_clear=1. i_enable=1 -> COARSE next cycle, good/bad/acq cleared.
//   COARSE: gain 10. win_end: e<=COARSE_THRESH ? good++ : good=0; acq++.
//           good reaches COARSE_WINDOWS -> FINE (good=0).
//   FINE:   gain 01. win_end: e<=FINE_THRESH ? good++ : good=0; acq++; good reaches LOCK_WINDOWS
//           -> LOCKED; e>COARSE_THRESH -> COARSE (good=0, acq kept).
//   LOCKED: gain 00, o_locked=1. win_end: e>FINE_THRESH ? bad++ : bad=0; bad reaches UNLOCK_WINDOWS -> LOST.
//   LOST:   exactly 1 cycle; lpf_clear=1, gain 10, set o_lock_lost; -> COARSE, good/bad/acq cleared.
//  Timeout: in COARSE/FINE, acq reaches ACQ_TIMEOUT at win_end -> LOST (overrides other transitions).
//  i_enable=0 in any state -> IDLE next cycle (highest priority after reset/scan).
//  o_lock_lost: set in LOST; cleared by i_clr_lost; set wins if same cycle.
//  Counters sized $clog2(param+1); good/bad never exceed threshold (transition clears).
//  Reset mid-operation: immediate async return to reset values; no partial window carried over.
//  Scan (i_scan_en=1): all flops shift, functional update frozen. Order from i_scan_in:
//   state[2:0] MSB first, good, bad, acq, err_cnt, div_q, o_lock_lost; o_scan_out = o_lock_lost flop.
// TESTING
//  Reset, i_enable=0, 20 windows of up pulses -> state 0, gain 10, lpf_clear=1, locked=0.
//  Enable; windows of 0 error: 4 windows -> FINE, +16 windows -> LOCKED, o_locked=1, gain 00.
//  LOCKED; 2 bad windows (e=5) then 1 clean -> stays locked; 3 bad windows -> LOST 1 cycle, lock_lost=1, COARSE.
//  FINE with window e=20 -> back to COARSE; e=255+ cycles saturates err_cnt at 255, no wrap.
//  Alternating e=2 in FINE for 1024 windows -> timeout LOST; i_clr_lost with LOST same cycle -> lock_lost stays 1.
//  Scan: shift known pattern through chain length bits, verify o_scan_out order and FSM state frozen.

Source files
------------

// File: rtl/tt_dpll_lock_ctrl.sv
// tt_dpll_lock_ctrl: DPLL acquisition/lock sequencer.
// Counts PFD activity per reference window (one i_clk_div period) and steps the loop filter
// gain COARSE -> FINE -> LOCKED, with hysteresis on lock loss and an acquisition timeout.
// All flops sit on one scan chain; shifting freezes the functional update.
module tt_dpll_lock_ctrl #(
  parameter int unsigned ERR_W          = 8,
  parameter int unsigned COARSE_THRESH  = 8,
  parameter int unsigned FINE_THRESH    = 1,
  parameter int unsigned COARSE_WINDOWS = 4,
  parameter int unsigned LOCK_WINDOWS   = 16,
  parameter int unsigned UNLOCK_WINDOWS = 3,
  parameter int unsigned ACQ_TIMEOUT    = 1024
) (
  input  logic       o_clk_gen,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_clk_div,
  input  logic       i_clr_lost,
  output logic [1:0] o_gain_sel,
  output logic       o_lpf_clear,
  output logic       o_locked,
  output logic       o_lock_lost,
  output logic [2:0] o_state,
  input  logic       i_scan_en,
  input  logic       i_scan_in,
  output logic       o_scan_out
);

  localparam int unsigned GoodMax = (COARSE_WINDOWS > LOCK_WINDOWS) ? COARSE_WINDOWS
                                                                     : LOCK_WINDOWS;
  localparam int unsigned GoodW   = $clog2(GoodMax + 1);
  localparam int unsigned BadW    = $clog2(UNLOCK_WINDOWS + 1);
  localparam int unsigned AcqW    = $clog2(ACQ_TIMEOUT + 1);
  localparam int unsigned ChainW  = 3 + GoodW + BadW + AcqW + ERR_W + 2;

  localparam logic [ERR_W-1:0] CoarseThr = ERR_W'(COARSE_THRESH);
  localparam logic [ERR_W-1:0] FineThr   = ERR_W'(FINE_THRESH);
  localparam logic [GoodW-1:0] CoarseWin = GoodW'(COARSE_WINDOWS);
  localparam logic [GoodW-1:0] LockWin   = GoodW'(LOCK_WINDOWS);
  localparam logic [BadW-1:0]  UnlockWin = BadW'(UNLOCK_WINDOWS);
  localparam logic [AcqW-1:0]  AcqLimit  = AcqW'(ACQ_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCoarse = 3'd1,
    StFine   = 3'd2,
    StLocked = 3'd3,
    StLost   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [BadW-1:0]    bad_q, bad_d;
  logic [AcqW-1:0]    acq_q, acq_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               div_q, div_d;
  logic               lock_lost_q, lock_lost_d;

  logic               act, win_end, coarse_ok, fine_ok;
  logic [GoodW-1:0]   good_inc;
  logic [BadW-1:0]    bad_inc;
  logic [AcqW-1:0]    acq_inc;
  logic [ChainW-1:0]  chain_shift;

  assign act       = i_up | i_down;
  assign win_end   = i_clk_div & ~div_q;
  // err_cnt_q holds the finished window's count on the win_end cycle
  assign coarse_ok = (err_cnt_q <= CoarseThr);
  assign fine_ok   = (err_cnt_q <= FineThr);
  assign good_inc  = good_q + GoodW'(1);
  assign bad_inc   = bad_q + BadW'(1);
  assign acq_inc   = acq_q + AcqW'(1);

  // Chain order from i_scan_in: state MSB first ... lock_lost last (drives o_scan_out)
  assign chain_shift = {i_scan_in, state_q, good_q, bad_q, acq_q, err_cnt_q, div_q};

  // Next-state: window counter, sequencer, sticky flag, then scan override
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    acq_d   = acq_q;
    div_d   = i_clk_div;

    if (win_end) begin
      err_cnt_d = ERR_W'(act);
    end else if (&err_cnt_q) begin
      err_cnt_d = err_cnt_q;
    end else begin
      err_cnt_d = err_cnt_q + ERR_W'(act);
    end

    case (state_q)
      StIdle: begin
        if (i_enable) begin
          state_d = StCoarse;
          good_d  = '0;
          bad_d   = '0;
          acq_d   = '0;
        end
      end
      StCoarse: begin
        if (win_end) begin
          acq_d  = acq_inc;
          good_d = coarse_ok ? good_inc : '0;
          if (acq_inc == AcqLimit) begin
            state_d = StLost;
          end else if (coarse_ok && (good_inc == CoarseWin)) begin
            state_d = StFine;
            good_d  = '0;
          end
        end
      end
      StFine: begin
        if (win_end) begin
          acq_d  = acq_inc;
          good_d = fine_ok ? good_inc : '0;
          if (acq_inc == AcqLimit) begin
            state_d = StLost;
          end else if (fine_ok && (good_inc == LockWin)) begin
            state_d = StLocked;
            good_d  = '0;
          end else if (!coarse_ok) begin
            state_d = StCoarse;
            good_d  = '0;
          end
        end
      end
      StLocked: begin
        if (win_end) begin
          bad_d = fine_ok ? '0 : bad_inc;
          if (!fine_ok && (bad_inc == UnlockWin)) begin
            state_d = StLost;
          end
        end
      end
      StLost: begin
        state_d = StCoarse;
        good_d  = '0;
        bad_d   = '0;
        acq_d   = '0;
      end
      default: begin
        state_d = StIdle;
        good_d  = '0;
        bad_d   = '0;
        acq_d   = '0;
      end
    endcase

    // LOST restarts acquisition, so its counters are never meaningful
    if (state_d == StLost) begin
      good_d = '0;
      bad_d  = '0;
      acq_d  = '0;
    end

    if (!i_enable) begin
      state_d = StIdle;
      good_d  = '0;
      bad_d   = '0;
      acq_d   = '0;
    end

    // Set wins over a simultaneous clear
    lock_lost_d = (state_d == StLost) | (lock_lost_q & ~i_clr_lost);

    if (i_scan_en) begin
      state_d = state_e'(chain_shift[ChainW-1 -: 3]);
      {good_d, bad_d, acq_d, err_cnt_d, div_d, lock_lost_d} = chain_shift[ChainW-4:0];
    end
  end

  // State and counter flops with asynchronous reset
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      good_q      <= '0;
      bad_q       <= '0;
      acq_q       <= '0;
      err_cnt_q   <= '0;
      div_q       <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      acq_q       <= acq_d;
      err_cnt_q   <= err_cnt_d;
      div_q       <= div_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Outputs decode the state flop, i.e. the registered next state, keeping the chain minimal
  always_comb begin
    o_gain_sel  = 2'b10;
    o_lpf_clear = 1'b0;
    o_locked    = 1'b0;
    case (state_q)
      StIdle:   o_lpf_clear = 1'b1;
      StFine:   o_gain_sel  = 2'b01;
      StLocked: begin
        o_gain_sel = 2'b00;
        o_locked   = 1'b1;
      end
      StLost:   o_lpf_clear = 1'b1;
      default:  o_gain_sel  = 2'b10;
    endcase
  end

  assign o_state     = state_q;
  assign o_lock_lost = lock_lost_q;
  assign o_scan_out  = lock_lost_q;

endmodule

// File: tb/tb_tt_dpll_lock_ctrl.sv
// Self-checking bench for tt_dpll_lock_ctrl: directed lock/unlock/timeout sequences and random
// windows, compared every cycle against a behavioural window-level model.
module tb_tt_dpll_lock_ctrl;

  localparam int ERR_W          = 8;
  localparam int COARSE_THRESH  = 8;
  localparam int FINE_THRESH    = 1;
  localparam int COARSE_WINDOWS = 4;
  localparam int LOCK_WINDOWS   = 16;
  localparam int UNLOCK_WINDOWS = 3;
  localparam int ACQ_TIMEOUT    = 1024;
  localparam int GOOD_W         = 5;
  localparam int BAD_W          = 2;
  localparam int ACQ_W          = 11;
  localparam int CHAIN_W        = 3 + GOOD_W + BAD_W + ACQ_W + ERR_W + 2;
  localparam int ERR_MAX        = (1 << ERR_W) - 1;

  localparam int S_IDLE = 0, S_COARSE = 1, S_FINE = 2, S_LOCKED = 3, S_LOST = 4;

  logic       o_clk_gen = 1'b0;
  logic       i_rst_n, i_enable, i_up, i_down, i_clk_div, i_clr_lost;
  logic       i_scan_en, i_scan_in;
  logic [1:0] o_gain_sel;
  logic       o_lpf_clear, o_locked, o_lock_lost, o_scan_out;
  logic [2:0] o_state;

  always #5 o_clk_gen = ~o_clk_gen;

  tt_dpll_lock_ctrl #(
    .ERR_W(ERR_W), .COARSE_THRESH(COARSE_THRESH), .FINE_THRESH(FINE_THRESH),
    .COARSE_WINDOWS(COARSE_WINDOWS), .LOCK_WINDOWS(LOCK_WINDOWS),
    .UNLOCK_WINDOWS(UNLOCK_WINDOWS), .ACQ_TIMEOUT(ACQ_TIMEOUT)
  ) dut (
    .o_clk_gen(o_clk_gen), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_up(i_up),
    .i_down(i_down), .i_clk_div(i_clk_div), .i_clr_lost(i_clr_lost),
    .o_gain_sel(o_gain_sel), .o_lpf_clear(o_lpf_clear), .o_locked(o_locked),
    .o_lock_lost(o_lock_lost), .o_state(o_state), .i_scan_en(i_scan_en),
    .i_scan_in(i_scan_in), .o_scan_out(o_scan_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit tb_en, tb_clr;

  // Reference model state
  int m_state, m_good, m_bad, m_acq, m_err, m_div, m_lost;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_good = 0; m_bad = 0; m_acq = 0; m_err = 0; m_div = 0; m_lost = 0;
  endtask

  function automatic int exp_gain(input int s);
    if (s == S_FINE) return 1;
    if (s == S_LOCKED) return 0;
    return 2;
  endfunction

  // One clock of the window-level rules
  task automatic model_clock(input bit act, input bit div);
    bit we;
    int e, ns, g, b, a;
    we = div && (m_div == 0);
    e  = m_err;
    ns = m_state; g = m_good; b = m_bad; a = m_acq;
    case (m_state)
      S_IDLE: if (tb_en) begin ns = S_COARSE; g = 0; b = 0; a = 0; end
      S_COARSE: if (we) begin
        a = a + 1;
        g = (e <= COARSE_THRESH) ? g + 1 : 0;
        if (a >= ACQ_TIMEOUT) ns = S_LOST;
        else if (g >= COARSE_WINDOWS) begin ns = S_FINE; g = 0; end
      end
      S_FINE: if (we) begin
        a = a + 1;
        g = (e <= FINE_THRESH) ? g + 1 : 0;
        if (a >= ACQ_TIMEOUT) ns = S_LOST;
        else if (g >= LOCK_WINDOWS) begin ns = S_LOCKED; g = 0; end
        else if (e > COARSE_THRESH) begin ns = S_COARSE; g = 0; end
      end
      S_LOCKED: if (we) begin
        b = (e > FINE_THRESH) ? b + 1 : 0;
        if (b >= UNLOCK_WINDOWS) ns = S_LOST;
      end
      S_LOST: begin ns = S_COARSE; g = 0; b = 0; a = 0; end
      default: ns = S_IDLE;
    endcase
    if (ns == S_LOST) begin g = 0; b = 0; a = 0; end
    if (!tb_en) begin ns = S_IDLE; g = 0; b = 0; a = 0; end
    if (ns == S_LOST) m_lost = 1;
    else if (tb_clr) m_lost = 0;
    if (we) m_err = act;
    else if (m_err + act > ERR_MAX) m_err = ERR_MAX;
    else m_err = m_err + act;
    m_div = div;
    m_state = ns; m_good = g; m_bad = b; m_acq = a;
  endtask

  task automatic compare_all();
    check("state", o_state, m_state);
    check("gain_sel", o_gain_sel, exp_gain(m_state));
    check("lpf_clear", o_lpf_clear, (m_state == S_IDLE || m_state == S_LOST));
    check("locked", o_locked, (m_state == S_LOCKED));
    check("lock_lost", o_lock_lost, m_lost);
    check("scan_out", o_scan_out, m_lost);
  endtask

  // Drive one cycle (called #1 after a rising edge), advance model, compare
  task automatic step(input logic up, input logic dn, input logic div);
    i_up = up; i_down = dn; i_clk_div = div; i_enable = tb_en; i_clr_lost = tb_clr;
    i_scan_en = 1'b0; i_scan_in = 1'b0;
    @(posedge o_clk_gen);
    model_clock(up | dn, div);
    #1;
    compare_all();
  endtask

  // Window: clk_div high for the first 2 cycles; nerr error cycles after the edge cycle
  task automatic do_window(input int len_in, input int nerr, input bit edge_err);
    int len;
    logic [1:0] r;
    len = len_in;
    if (len < nerr + 1) len = nerr + 1;
    if (len < 3) len = 3;
    for (int c = 0; c < len; c++) begin
      bit act;
      act = (c >= 1 && c <= nerr) || (c == 0 && edge_err);
      r = 2'($urandom_range(1, 3));
      step(act & r[0], act & r[1], c < 2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    bit old_bits[$];
    logic [CHAIN_W-1:0] pat;
    logic exp_bit;

    i_rst_n = 1'b0; i_enable = 1'b0; i_up = 1'b0; i_down = 1'b0; i_clk_div = 1'b0;
    i_clr_lost = 1'b0; i_scan_en = 1'b0; i_scan_in = 1'b0;
    tb_en = 1'b0; tb_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge o_clk_gen);
    #1;
    check("rst_state", o_state, 0);
    check("rst_gain", o_gain_sel, 2);
    check("rst_lpf_clear", o_lpf_clear, 1);
    check("rst_locked", o_locked, 0);
    check("rst_lock_lost", o_lock_lost, 0);
    i_rst_n = 1'b1;

    // Disabled: 20 windows with up pulses stay in IDLE
    for (int w = 0; w < 20; w++) do_window(6, 3, 1'b0);
    check("idle_state", o_state, 0);
    check("idle_gain", o_gain_sel, 2);
    check("idle_lpf_clear", o_lpf_clear, 1);
    check("idle_locked", o_locked, 0);
    do_window(4, 0, 1'b0);

    // Clean acquisition: 4 windows to FINE, 16 more to LOCKED
    tb_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("enable_coarse", o_state, 1);
    for (int w = 0; w < 3; w++) do_window(4, 0, 1'b0);
    check("coarse_3win", o_state, 1);
    do_window(4, 0, 1'b0);
    check("fine_4win", o_state, 2);
    check("fine_gain", o_gain_sel, 1);
    for (int w = 0; w < 15; w++) do_window(4, 0, 1'b0);
    check("fine_15win", o_state, 2);
    do_window(4, 0, 1'b0);
    check("locked_state", o_state, 3);
    check("locked_flag", o_locked, 1);
    check("locked_gain", o_gain_sel, 0);

    // Hysteresis: 2 bad + 1 clean keeps lock, then 3 bad -> LOST
    do_window(8, 5, 1'b0); do_window(8, 5, 1'b0); do_window(8, 0, 1'b0);
    do_window(8, 5, 1'b0); do_window(8, 5, 1'b0); do_window(8, 5, 1'b0);
    check("hyst_still_locked", o_locked, 1);
    step(1'b0, 1'b0, 1'b1);
    check("lost_state", o_state, 4);
    check("lost_flag", o_lock_lost, 1);
    check("lost_lpf_clear", o_lpf_clear, 1);
    check("lost_gain", o_gain_sel, 2);
    step(1'b0, 1'b0, 1'b1);
    check("lost_to_coarse", o_state, 1);
    check("lost_sticky", o_lock_lost, 1);
    step(1'b0, 1'b0, 1'b0);

    // FINE falls back to COARSE on a large-error window; saturation must not wrap to 0
    for (int w = 0; w < 6; w++) do_window(4, 0, 1'b0);
    check("refine_state", o_state, 2);
    do_window(25, 20, 1'b0);
    do_window(4, 0, 1'b0);
    check("fine_to_coarse", o_state, 1);
    for (int w = 0; w < 5; w++) do_window(4, 0, 1'b0);
    check("refine2_state", o_state, 2);
    do_window(260, 256, 1'b0);
    do_window(4, 0, 1'b0);
    check("sat_no_wrap", o_state, 1);

    tb_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tb_clr = 1'b0;
    check("clr_lost", o_lock_lost, 0);

    // Acquisition timeout with alternating e=2 / e=0 windows
    found = 1'b0;
    for (int w = 0; w < 1100 && !found; w++) begin
      if ((m_state == S_FINE || m_state == S_COARSE) && m_acq == ACQ_TIMEOUT - 1) found = 1'b1;
      else do_window(4, (w % 2 == 0) ? 2 : 0, 1'b0);
    end
    check("timeout_reached", found, 1);
    check("timeout_in_fine", o_state, 2);
    tb_clr = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    check("timeout_lost", o_state, 4);
    check("set_beats_clr", o_lock_lost, 1);
    step(1'b0, 1'b0, 1'b1);
    check("timeout_coarse", o_state, 1);
    check("clr_after_lost", o_lock_lost, 0);
    tb_clr = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Random windows
    for (int w = 0; w < 300; w++) begin
      int r, nerr;
      tb_en  = ($urandom_range(0, 49) != 0);
      tb_clr = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) nerr = 0;
      else if (r < 7) nerr = $urandom_range(0, 2);
      else if (r < 9) nerr = $urandom_range(0, 10);
      else nerr = $urandom_range(5, 15);
      do_window($urandom_range(3, 20), nerr, $urandom_range(0, 3) == 0);
    end
    tb_en = 1'b1; tb_clr = 1'b0;
    for (int w = 0; w < 3; w++) do_window(5, 1, 1'b0);

    // Scan: unload current contents, load a pattern, function frozen throughout
    for (int i = 0; i < 1; i++) old_bits.push_back(m_lost[0]);
    old_bits.push_back(m_div[0]);
    for (int i = 0; i < ERR_W; i++) old_bits.push_back(((m_err >> i) & 1) != 0);
    for (int i = 0; i < ACQ_W; i++) old_bits.push_back(((m_acq >> i) & 1) != 0);
    for (int i = 0; i < BAD_W; i++) old_bits.push_back(((m_bad >> i) & 1) != 0);
    for (int i = 0; i < GOOD_W; i++) old_bits.push_back(((m_good >> i) & 1) != 0);
    for (int i = 0; i < 3; i++) old_bits.push_back(((m_state >> i) & 1) != 0);
    pat = CHAIN_W'($urandom);
    pat[28] = 1'b1;
    for (int k = 0; k < 2 * CHAIN_W; k++) begin
      exp_bit = (k < CHAIN_W) ? old_bits[k] : pat[k - CHAIN_W];
      check("scan_bit", o_scan_out, exp_bit);
      i_scan_en = 1'b1; i_enable = 1'b0; i_clr_lost = 1'b1;
      i_scan_in = pat[k % CHAIN_W];
      i_clk_div = k[0]; i_up = 1'b1; i_down = k[1];
      @(posedge o_clk_gen);
      #1;
    end
    check("scan_state", o_state, {pat[30], pat[29], pat[28]});
    check("scan_lock_lost", o_lock_lost, pat[0]);

    // Asynchronous reset mid-cycle
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_state", o_state, 0);
    check("arst_gain", o_gain_sel, 2);
    check("arst_lpf_clear", o_lpf_clear, 1);
    check("arst_lock_lost", o_lock_lost, 0);
    check("arst_scan_out", o_scan_out, 0);
    model_reset();
    i_scan_en = 1'b0; i_clr_lost = 1'b0; i_up = 1'b0; i_down = 1'b0; i_clk_div = 1'b0;
    @(posedge o_clk_gen);
    #1;
    i_rst_n = 1'b1;
    tb_en = 1'b1;
    for (int w = 0; w < 25; w++) do_window(4, 0, 1'b0);
    check("post_reset_locked", o_locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
